// File: rtl/sparse_pair_mem.sv
// sparse_pair_mem: two-channel (index, value) pair store with append-only writes.
// A read-out either dumps both channels side by side or intersects their
// ascending index lists with a two-pointer merge, streaming each result
// through a valid/ready output port.
module sparse_pair_mem #(
   parameter int DW = 8,
   parameter int IW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en1,
   input  logic [IW-1:0] i1,
   input  logic [DW-1:0] din1,
   input  logic          wr_en2,
   input  logic [IW-1:0] i2,
   input  logic [DW-1:0] din2,
   input  logic          clr,
   input  logic          start,
   input  logic          mode,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [IW-1:0] r1,
   output logic [DW-1:0] out1,
   output logic [IW-1:0] r2,
   output logic [DW-1:0] out2,
   output logic [AW:0]   len1,
   output logic [AW:0]   len2,
   output logic          full1,
   output logic          full2,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   match_cnt
);

   localparam int DEPTH = 2 ** AW;
   localparam int PW    = AW + 1;
   localparam int EW    = IW + DW;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      EMIT,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [EW-1:0] mem1 [DEPTH];
   logic [EW-1:0] mem2 [DEPTH];

   logic          mode_q, mode_d;
   logic [PW-1:0] len1_q, len1_d;
   logic [PW-1:0] len2_q, len2_d;
   logic [PW-1:0] p1_q, p1_d;
   logic [PW-1:0] p2_q, p2_d;
   logic [PW-1:0] match_cnt_q, match_cnt_d;
   logic [IW-1:0] r1_q, r1_d;
   logic [DW-1:0] out1_q, out1_d;
   logic [IW-1:0] r2_q, r2_d;
   logic [DW-1:0] out2_q, out2_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          full1_c, full2_c;
   logic          wr1_accept, wr2_accept;
   logic [PW-1:0] max_len;
   logic [PW-1:0] rd2_ptr;
   logic [EW-1:0] rd1_entry, rd2_entry;
   logic [IW-1:0] idx1, idx2;
   logic [DW-1:0] val1, val2;
   logic          run_end, run_emit;

   assign full1_c = (len1_q == PW'(DEPTH));
   assign full2_c = (len2_q == PW'(DEPTH));

   // clr takes priority over an append, and appends are only taken while idle
   assign wr1_accept = (state_q == IDLE) && wr_en1 && !full1_c && !clr;
   assign wr2_accept = (state_q == IDLE) && wr_en2 && !full2_c && !clr;

   // Dump mode walks both channels with the single pointer p1
   assign rd2_ptr   = mode_q ? p2_q : p1_q;
   assign rd1_entry = mem1[p1_q[AW-1:0]];
   assign rd2_entry = mem2[rd2_ptr[AW-1:0]];
   assign idx1      = rd1_entry[EW-1:DW];
   assign val1      = rd1_entry[DW-1:0];
   assign idx2      = rd2_entry[EW-1:DW];
   assign val2      = rd2_entry[DW-1:0];
   assign max_len   = (len1_q > len2_q) ? len1_q : len2_q;

   assign run_end  = mode_q ? ((p1_q >= len1_q) || (p2_q >= len2_q))
                            : (p1_q >= max_len);
   assign run_emit = mode_q ? (idx1 == idx2) : 1'b1;

   // Pair storage: appends land at the current fill count, never cleared
   always_ff @(posedge clk) begin
      if (wr1_accept) begin
         mem1[len1_q[AW-1:0]] <= {i1, din1};
      end
      if (wr2_accept) begin
         mem2[len2_q[AW-1:0]] <= {i2, din2};
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         len1_q      <= '0;
         len2_q      <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         match_cnt_q <= '0;
         r1_q        <= '0;
         out1_q      <= '0;
         r2_q        <= '0;
         out2_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         len1_q      <= len1_d;
         len2_q      <= len2_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         match_cnt_q <= match_cnt_d;
         r1_q        <= r1_d;
         out1_q      <= out1_d;
         r2_q        <= r2_d;
         out2_q      <= out2_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state selection for the read-out sequencer
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            if (run_end) begin
               state_d = DONE;
            end else if (run_emit) begin
               state_d = EMIT;
            end
         end
         EMIT: if (out_ready) state_d = RUN;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-state updates of fill counts, pointers, output pair and status flags
   always_comb begin
      mode_d      = mode_q;
      len1_d      = len1_q;
      len2_d      = len2_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      match_cnt_d = match_cnt_q;
      r1_d        = r1_q;
      out1_d      = out1_q;
      r2_d        = r2_q;
      out2_d      = out2_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr) begin
               len1_d = '0;
               len2_d = '0;
            end else begin
               if (wr1_accept) len1_d = len1_q + PW'(1);
               if (wr2_accept) len2_d = len2_q + PW'(1);
            end
            if (start) begin
               mode_d      = mode;
               p1_d        = '0;
               p2_d        = '0;
               match_cnt_d = '0;
               busy_d      = 1'b1;
            end
         end
         RUN: begin
            if (run_end) begin
               done_d = 1'b1;
            end else if (!mode_q) begin
               r1_d        = (p1_q < len1_q) ? idx1 : '0;
               out1_d      = (p1_q < len1_q) ? val1 : '0;
               r2_d        = (p1_q < len2_q) ? idx2 : '0;
               out2_d      = (p1_q < len2_q) ? val2 : '0;
               p1_d        = p1_q + PW'(1);
               match_cnt_d = match_cnt_q + PW'(1);
               out_valid_d = 1'b1;
            end else if (idx1 == idx2) begin
               r1_d        = idx1;
               out1_d      = val1;
               r2_d        = idx2;
               out2_d      = val2;
               p1_d        = p1_q + PW'(1);
               p2_d        = p2_q + PW'(1);
               match_cnt_d = match_cnt_q + PW'(1);
               out_valid_d = 1'b1;
            end else if (idx1 < idx2) begin
               p1_d = p1_q + PW'(1);
            end else begin
               p2_d = p2_q + PW'(1);
            end
         end
         EMIT: begin
            if (out_ready) out_valid_d = 1'b0;
         end
         DONE: begin
            busy_d = 1'b0;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign out_valid = out_valid_q;
   assign r1        = r1_q;
   assign out1      = out1_q;
   assign r2        = r2_q;
   assign out2      = out2_q;
   assign len1      = len1_q;
   assign len2      = len2_q;
   assign full1     = full1_c;
   assign full2     = full2_c;
   assign busy      = busy_q;
   assign done      = done_q;
   assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_sparse_pair_mem.sv
// tb_sparse_pair_mem: directed vector table for write/clr/dump behaviour plus
// hand-written sequences for empty read-out, match with backpressure, fill
// limit and reset during an emitted beat.
module tb_sparse_pair_mem;

   localparam int DW = 8;
   localparam int IW = 8;
   localparam int AW = 4;
   localparam int NV = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en1, wr_en2, clr, start, mode, out_ready;
   logic [IW-1:0] i1, i2;
   logic [DW-1:0] din1, din2;
   logic          out_valid, full1, full2, busy, done;
   logic [IW-1:0] r1, r2;
   logic [DW-1:0] out1, out2;
   logic [AW:0]   len1, len2, match_cnt;

   int checks   = 0;
   int failures = 0;
   int beat_cnt = 0;
   int done_cnt = 0;

   typedef struct {
      logic          wr1;
      logic [IW-1:0] i1;
      logic [DW-1:0] d1;
      logic          wr2;
      logic [IW-1:0] i2;
      logic [DW-1:0] d2;
      logic          clr;
      logic          start;
      logic          mode;
      logic          rdy;
      logic [AW:0]   e_len1;
      logic [AW:0]   e_len2;
      logic          e_busy;
      logic          e_done;
      logic          e_valid;
      logic [IW-1:0] e_r1;
      logic [DW-1:0] e_o1;
      logic [IW-1:0] e_r2;
      logic [DW-1:0] e_o2;
      logic [AW:0]   e_cnt;
   } vec_t;

   vec_t vecs [NV];

   sparse_pair_mem #(.DW(DW), .IW(IW), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en1    (wr_en1),
      .i1        (i1),
      .din1      (din1),
      .wr_en2    (wr_en2),
      .i2        (i2),
      .din2      (din2),
      .clr       (clr),
      .start     (start),
      .mode      (mode),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .r1        (r1),
      .out1      (out1),
      .r2        (r2),
      .out2      (out2),
      .len1      (len1),
      .len2      (len2),
      .full1     (full1),
      .full2     (full2),
      .busy      (busy),
      .done      (done),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;

   // Count accepted beats and done pulses midway between clock edges
   always @(negedge clk) begin
      if (out_valid && out_ready) beat_cnt++;
      if (done) done_cnt++;
   end

   function automatic vec_t mk(input int wr1, input int a1, input int b1,
                               input int wr2, input int a2, input int b2,
                               input int c, input int st, input int md, input int rd,
                               input int l1, input int l2, input int bs, input int dn,
                               input int vl, input int er1, input int eo1,
                               input int er2, input int eo2, input int cn);
      vec_t v;
      v.wr1 = 1'(wr1);     v.i1 = IW'(a1);       v.d1 = DW'(b1);
      v.wr2 = 1'(wr2);     v.i2 = IW'(a2);       v.d2 = DW'(b2);
      v.clr = 1'(c);       v.start = 1'(st);     v.mode = 1'(md);   v.rdy = 1'(rd);
      v.e_len1 = (AW+1)'(l1);  v.e_len2 = (AW+1)'(l2);
      v.e_busy = 1'(bs);   v.e_done = 1'(dn);    v.e_valid = 1'(vl);
      v.e_r1 = IW'(er1);   v.e_o1 = DW'(eo1);    v.e_r2 = IW'(er2); v.e_o2 = DW'(eo2);
      v.e_cnt = (AW+1)'(cn);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      wr_en1 = 1'b0; i1 = '0; din1 = '0;
      wr_en2 = 1'b0; i2 = '0; din2 = '0;
      clr = 1'b0; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
   endtask

   task automatic doReset();
      clearInputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int k);
      wr_en1 = v.wr1; i1 = v.i1; din1 = v.d1;
      wr_en2 = v.wr2; i2 = v.i2; din2 = v.d2;
      clr = v.clr; start = v.start; mode = v.mode; out_ready = v.rdy;
      step();
      checkOutput($sformatf("v%0d.len1", k), 32'(len1), 32'(v.e_len1));
      checkOutput($sformatf("v%0d.len2", k), 32'(len2), 32'(v.e_len2));
      checkOutput($sformatf("v%0d.busy", k), 32'(busy), 32'(v.e_busy));
      checkOutput($sformatf("v%0d.done", k), 32'(done), 32'(v.e_done));
      checkOutput($sformatf("v%0d.out_valid", k), 32'(out_valid), 32'(v.e_valid));
      checkOutput($sformatf("v%0d.r1", k), 32'(r1), 32'(v.e_r1));
      checkOutput($sformatf("v%0d.out1", k), 32'(out1), 32'(v.e_o1));
      checkOutput($sformatf("v%0d.r2", k), 32'(r2), 32'(v.e_r2));
      checkOutput($sformatf("v%0d.out2", k), 32'(out2), 32'(v.e_o2));
      checkOutput($sformatf("v%0d.match_cnt", k), 32'(match_cnt), 32'(v.e_cnt));
   endtask

   task automatic waitValid(input string name, input int limit);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < limit; n++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      checkOutput({name, "_arrived"}, 32'(ok), 32'd1);
   endtask

   task automatic waitDone(input string name, input int limit);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < limit; n++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      checkOutput({name, "_arrived"}, 32'(ok), 32'd1);
   endtask

   task automatic checkPair(input string name, input int er1, input int eo1,
                            input int er2, input int eo2);
      checkOutput({name, ".r1"}, 32'(r1), 32'(er1));
      checkOutput({name, ".out1"}, 32'(out1), 32'(eo1));
      checkOutput({name, ".r2"}, 32'(r2), 32'(er2));
      checkOutput({name, ".out2"}, 32'(out2), 32'(eo2));
   endtask

   initial begin
      int c1i [4] = '{1, 3, 5, 7};
      int c1v [4] = '{11, 33, 55, 77};
      int c2i [3] = '{3, 4, 7};
      int c2v [3] = '{2, 4, 6};

      // Columns: wr1,i1,d1, wr2,i2,d2, clr,start,mode,rdy | len1,len2,busy,done,valid, r1,o1,r2,o2, cnt
      vecs[0]  = mk(1,1,10, 1,1,5,  0,0,0,1,  1,1,0,0,0,  0,0,0,0,   0);
      vecs[1]  = mk(1,3,30, 0,0,0,  0,0,0,1,  2,1,0,0,0,  0,0,0,0,   0);
      vecs[2]  = mk(1,5,50, 0,0,0,  1,0,0,1,  0,0,0,0,0,  0,0,0,0,   0);
      vecs[3]  = mk(1,1,10, 1,1,5,  0,0,0,1,  1,1,0,0,0,  0,0,0,0,   0);
      vecs[4]  = mk(1,3,30, 0,0,0,  0,0,0,1,  2,1,0,0,0,  0,0,0,0,   0);
      vecs[5]  = mk(0,0,0,  0,0,0,  0,1,0,1,  2,1,1,0,0,  0,0,0,0,   0);
      vecs[6]  = mk(1,9,90, 0,0,0,  0,0,0,1,  2,1,1,0,1,  1,10,1,5,  1);
      vecs[7]  = mk(0,0,0,  0,0,0,  0,1,0,1,  2,1,1,0,0,  1,10,1,5,  1);
      vecs[8]  = mk(1,9,90, 0,0,0,  0,1,0,1,  2,1,1,0,1,  3,30,0,0,  2);
      vecs[9]  = mk(0,0,0,  0,0,0,  0,0,0,1,  2,1,1,0,0,  3,30,0,0,  2);
      vecs[10] = mk(0,0,0,  0,0,0,  0,0,0,1,  2,1,1,1,0,  3,30,0,0,  2);
      vecs[11] = mk(0,0,0,  0,0,0,  0,0,0,1,  2,1,0,0,0,  3,30,0,0,  2);

      // Reset state
      doReset();
      checkOutput("rst.len1", 32'(len1), 32'd0);
      checkOutput("rst.len2", 32'(len2), 32'd0);
      checkOutput("rst.busy", 32'(busy), 32'd0);
      checkOutput("rst.done", 32'(done), 32'd0);
      checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst.full1", 32'(full1), 32'd0);
      checkOutput("rst.match_cnt", 32'(match_cnt), 32'd0);
      checkPair("rst", 0, 0, 0, 0);

      // Writes, clr priority, dump read-out, writes and starts ignored while busy
      for (int k = 0; k < NV; k++) begin
         applyStimulus(vecs[k], k);
      end
      clearInputs();

      // Empty read-out: done two cycles after start, nothing emitted
      doReset();
      start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("empty.busy1", 32'(busy), 32'd1);
      checkOutput("empty.done_early", 32'(done), 32'd0);
      step();
      checkOutput("empty.done", 32'(done), 32'd1);
      checkOutput("empty.match_cnt", 32'(match_cnt), 32'd0);
      checkOutput("empty.valid", 32'(out_valid), 32'd0);
      step();
      checkOutput("empty.done_off", 32'(done), 32'd0);
      checkOutput("empty.busy0", 32'(busy), 32'd0);

      // Match mode with backpressure on the first beat
      doReset();
      for (int k = 0; k < 4; k++) begin
         wr_en1 = 1'b1; i1 = IW'(c1i[k]); din1 = DW'(c1v[k]);
         wr_en2 = (k < 3);
         i2   = (k < 3) ? IW'(c2i[k]) : '0;
         din2 = (k < 3) ? DW'(c2v[k]) : '0;
         step();
      end
      clearInputs();
      checkOutput("match.len1", 32'(len1), 32'd4);
      checkOutput("match.len2", 32'(len2), 32'd3);
      beat_cnt = 0;
      done_cnt = 0;
      start = 1'b1; mode = 1'b1; out_ready = 1'b0;
      step();
      start = 1'b0; mode = 1'b0;
      waitValid("match.beat0", 40);
      checkPair("match.beat0", 3, 33, 3, 2);
      for (int n = 0; n < 5; n++) begin
         step();
         checkOutput($sformatf("bp%0d.valid", n), 32'(out_valid), 32'd1);
         checkOutput($sformatf("bp%0d.r1", n), 32'(r1), 32'd3);
         checkOutput($sformatf("bp%0d.out1", n), 32'(out1), 32'd33);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput("bp.released", 32'(out_valid), 32'd0);
      checkOutput("bp.beats", 32'(beat_cnt), 32'd1);
      waitValid("match.beat1", 40);
      checkPair("match.beat1", 7, 77, 7, 6);
      out_ready = 1'b1;
      step();
      checkOutput("match.beat1_taken", 32'(out_valid), 32'd0);
      waitDone("match.done", 40);
      checkOutput("match.match_cnt", 32'(match_cnt), 32'd2);
      checkOutput("match.beats", 32'(beat_cnt), 32'd2);
      step();
      checkOutput("match.done_off", 32'(done), 32'd0);
      checkOutput("match.busy0", 32'(busy), 32'd0);
      checkOutput("match.done_pulses", 32'(done_cnt), 32'd1);
      clearInputs();

      // Fill channel 1, overflow write dropped, then reset during an emitted beat
      doReset();
      for (int k = 0; k < 16; k++) begin
         wr_en1 = 1'b1; i1 = IW'(2 * k); din1 = DW'(k + 1);
         step();
      end
      clearInputs();
      checkOutput("fill.len1", 32'(len1), 32'd16);
      checkOutput("fill.full1", 32'(full1), 32'd1);
      checkOutput("fill.full2", 32'(full2), 32'd0);
      wr_en1 = 1'b1; i1 = 8'hAA; din1 = 8'hBB;
      step();
      clearInputs();
      checkOutput("over.len1", 32'(len1), 32'd16);
      checkOutput("over.full1", 32'(full1), 32'd1);
      start = 1'b1; mode = 1'b0; out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int b = 0; b < 3; b++) begin
         waitValid($sformatf("dump%0d", b), 20);
         checkPair($sformatf("dump%0d", b), 2 * b, b + 1, 0, 0);
         step();
      end
      out_ready = 1'b0;
      waitValid("dump3", 20);
      checkPair("dump3", 6, 4, 0, 0);
      done_cnt = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("rstmid.valid", 32'(out_valid), 32'd0);
      checkOutput("rstmid.busy", 32'(busy), 32'd0);
      checkOutput("rstmid.len1", 32'(len1), 32'd0);
      checkOutput("rstmid.len2", 32'(len2), 32'd0);
      checkOutput("rstmid.done", 32'(done), 32'd0);
      out_ready = 1'b1;
      repeat (20) step();
      checkOutput("rstmid.no_done", 32'(done_cnt), 32'd0);
      checkOutput("rstmid.idle", 32'(busy), 32'd0);
      checkOutput("rstmid.no_beat", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
